// File: rtl/byte_lane_dly_seq.sv
// Delay-programming sequencer: keeps a shadow table of per-lane IDELAY/ODELAY values,
// streams it into the byte lanes on request and commits it with one common set pulse.
module byte_lane_dly_seq #(
    parameter int unsigned NUM_LANES     = 2,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                 clk_div,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [1:0]           wr_lane_i,
    input  logic [4:0]           wr_addr_i,
    input  logic [7:0]           wr_data_i,
    input  logic [1:0]           rd_lane_i,
    input  logic [4:0]           rd_addr_i,
    output logic [7:0]           rd_data_o,
    input  logic                 apply_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [7:0]           dly_data_o,
    output logic [4:0]           dly_addr_o,
    output logic [NUM_LANES-1:0] ld_delay_o,
    output logic                 set_o
);

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = 4;
    localparam int unsigned NSLOT = 19;
    localparam int unsigned LW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SET, S_SETTLE} state_t;

    function automatic logic [LW-1:0] lane_map(input logic [1:0] l);
        return LW'(32'(l) % NUM_LANES);
    endfunction

    function automatic logic addr_valid(input logic [AW-1:0] a);
        return (a <= AW'(9)) || ((a >= AW'(16)) && (a <= AW'(24)));
    endfunction

    // Compacts the sparse lane address map into 19 dense slots; holes map to slot 0.
    function automatic logic [AW-1:0] slot_of(input logic [AW-1:0] a);
        if (a <= AW'(9)) return a;
        else if ((a >= AW'(16)) && (a <= AW'(24))) return a - AW'(6);
        else return '0;
    endfunction

    logic [DW-1:0]        tbl_q [NUM_LANES][NSLOT];

    state_t               state_q, state_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 set_q, set_d;
    logic [NUM_LANES-1:0] ld_q, ld_d;
    logic [DW-1:0]        dly_data_q, dly_data_d;
    logic [AW-1:0]        dly_addr_q, dly_addr_d;
    logic [DW-1:0]        rd_data_q, rd_data_d;

    logic [LW-1:0]        wr_lane_idx, rd_lane_idx, seq_lane;
    logic [AW-1:0]        seq_addr;
    logic [DW-1:0]        seq_val;

    assign wr_lane_idx = lane_map(wr_lane_i);
    assign rd_lane_idx = lane_map(rd_lane_i);
    assign seq_lane    = (state_q == S_IDLE) ? '0 : lane_q;
    assign seq_addr    = (state_q == S_IDLE) ? '0 : addr_q;
    assign seq_val     = tbl_q[seq_lane][slot_of(seq_addr)];
    assign rd_data_d   = addr_valid(rd_addr_i) ? tbl_q[rd_lane_idx][slot_of(rd_addr_i)] : '0;

    // Shadow table survives rst so a reset mid-pass does not lose programmed values.
    always_ff @(posedge clk_div) begin
        if (wr_en_i && addr_valid(wr_addr_i)) begin
            tbl_q[wr_lane_idx][slot_of(wr_addr_i)] <= wr_data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        set_d      = 1'b0;
        ld_d       = '0;
        dly_data_d = dly_data_q;
        dly_addr_d = dly_addr_q;

        unique case (state_q)
            S_IDLE: begin
                // A pending pass re-enters LOAD already emitting slot 0, keeping the
                // same done-to-done spacing as a pass started by apply.
                if (pend_q) begin
                    state_d    = S_LOAD;
                    busy_d     = 1'b1;
                    pend_d     = 1'b0;
                    lane_d     = '0;
                    addr_d     = AW'(1);
                    ld_d       = NUM_LANES'(1);
                    dly_data_d = seq_val;
                    dly_addr_d = '0;
                end else if (apply_i) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    lane_d  = '0;
                    addr_d  = '0;
                end
            end
            S_LOAD: begin
                ld_d       = NUM_LANES'(1) << lane_q;
                dly_data_d = seq_val;
                dly_addr_d = addr_q;
                if (addr_q == AW'(9)) begin
                    addr_d = AW'(16);
                end else if (addr_q == AW'(24)) begin
                    addr_d = '0;
                    if (lane_q == LAST_LANE) state_d = S_SET;
                    else                     lane_d  = lane_q + LW'(1);
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_SET: begin
                set_d   = 1'b1;
                cnt_d   = CW'(SETTLE_CYCLES);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase

        // Requests arriving mid-pass, or a write alongside apply, collapse into one extra pass.
        if (((state_q != S_IDLE) && (apply_i || wr_en_i)) ||
            ((state_q == S_IDLE) && apply_i && wr_en_i)) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            set_q      <= 1'b0;
            ld_q       <= '0;
            dly_data_q <= '0;
            dly_addr_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            set_q      <= set_d;
            ld_q       <= ld_d;
            dly_data_q <= dly_data_d;
            dly_addr_q <= dly_addr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign set_o      = set_q;
    assign ld_delay_o = ld_q;
    assign dly_data_o = dly_data_q;
    assign dly_addr_o = dly_addr_q;

endmodule

// File: tb/tb_byte_lane_dly_seq.sv
// Directed bench for byte_lane_dly_seq (NUM_LANES=2, SETTLE_CYCLES=3); outputs
// are sampled on the falling edge, cycle T is the rising edge that samples apply.
module tb_byte_lane_dly_seq;

    logic       clk_div = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_lane = '0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] rd_lane = '0;
    logic [4:0] rd_addr = '0;
    logic       apply   = 1'b0;
    logic [7:0] rd_data;
    logic       busy, done, set;
    logic [7:0] dly_data;
    logic [4:0] dly_addr;
    logic [1:0] ld_delay;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_tbl [2][32];
    logic [1:0] r_ld   [256];
    logic [4:0] r_addr [256];
    logic [7:0] r_data [256];
    logic       r_set  [256];
    logic       r_done [256];
    logic       r_busy [256];

    always #5 clk_div = ~clk_div;

    byte_lane_dly_seq #(.NUM_LANES(2), .SETTLE_CYCLES(3)) dut (
        .clk_div    (clk_div),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_lane_i  (wr_lane),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_lane_i  (rd_lane),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .apply_i    (apply),
        .busy_o     (busy),
        .done_o     (done),
        .dly_data_o (dly_data),
        .dly_addr_o (dly_addr),
        .ld_delay_o (ld_delay),
        .set_o      (set)
    );

    function automatic bit addr_ok(input logic [4:0] a);
        return (a <= 5'd9) || ((a >= 5'd16) && (a <= 5'd24));
    endfunction

    function automatic int seq_addr(input int j);
        int k;
        k = j % 19;
        return (k < 10) ? k : k + 6;
    endfunction

    function automatic logic [1:0] seq_ld(input int j);
        return ((j / 19) == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic wr_entry(input logic l, input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_lane = {1'b0, l}; wr_addr = a; wr_data = d;
        @(negedge clk_div);
        wr_en = 1'b0;
        if (addr_ok(a)) exp_tbl[l][a] = d;
    endtask

    task automatic kick();
        apply = 1'b1;
        @(negedge clk_div);
        apply = 1'b0;
    endtask

    // Records outputs at T+1..T+n, optionally injecting apply or a write sampled at T+k.
    task automatic run_capture(input int n, input int apply_at, input int wr_at,
                               input logic [1:0] wl, input logic [4:0] wa, input logic [7:0] wd);
        for (int i = 1; i <= n; i++) begin
            apply = (i == apply_at);
            wr_en = (i == wr_at);
            if (i == wr_at) begin
                wr_lane = wl; wr_addr = wa; wr_data = wd;
                if (addr_ok(wa)) exp_tbl[wl[0]][wa] = wd;
            end
            @(negedge clk_div);
            r_ld[8'(i)] = ld_delay; r_addr[8'(i)] = dly_addr; r_data[8'(i)] = dly_data;
            r_set[8'(i)] = set; r_done[8'(i)] = done; r_busy[8'(i)] = busy;
        end
        apply = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, set, ld_delay, dly_data, dly_addr, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b set=%b ld=%b data=%h addr=%0d rd=%h expected all zero",
                     busy, done, set, ld_delay, dly_data, dly_addr, rd_data);
        end
        @(negedge clk_div);
        rst = 1'b0;
        @(negedge clk_div);
        checks++;
        if (busy !== 1'b0 || ld_delay !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle busy=%b ld=%b expected 0 00", busy, ld_delay);
        end
    endtask

    task automatic init_table();
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < 32; a++) begin
                exp_tbl[1'(l)][5'(a)] = '0;
                if (addr_ok(5'(a))) wr_entry(1'(l), 5'(a), 8'(l * 64 + a * 2 + 1));
            end
        end
        wr_entry(1'b0, 5'd3, 8'h5A);
        wr_entry(1'b1, 5'd24, 8'hC7);
    endtask

    task automatic test_basic();
        kick();
        run_capture(44, 0, 0, 2'd0, 5'd0, 8'h00);
        for (int j = 0; j < 38; j++) begin
            checks++;
            if (r_ld[8'(j + 1)] !== seq_ld(j) || r_addr[8'(j + 1)] !== 5'(seq_addr(j)) ||
                r_data[8'(j + 1)] !== exp_tbl[1'(j / 19)][5'(seq_addr(j))]) begin
                errors++;
                $display("FAIL basic_slot T+%0d got ld=%b addr=%0d data=%h expected ld=%b addr=%0d data=%h",
                         j + 1, r_ld[8'(j + 1)], r_addr[8'(j + 1)], r_data[8'(j + 1)], seq_ld(j),
                         seq_addr(j), exp_tbl[1'(j / 19)][5'(seq_addr(j))]);
            end
        end
        checks++;
        if (r_addr[4] !== 5'd3 || r_data[4] !== 8'h5A || r_ld[4] !== 2'b01) begin
            errors++;
            $display("FAIL basic_t4 got addr=%0d data=%h ld=%b expected 3 5a 01", r_addr[4], r_data[4], r_ld[4]);
        end
        checks++;
        if (r_addr[38] !== 5'd24 || r_data[38] !== 8'hC7 || r_ld[38] !== 2'b10) begin
            errors++;
            $display("FAIL basic_t38 got addr=%0d data=%h ld=%b expected 24 c7 10", r_addr[38], r_data[38], r_ld[38]);
        end
        for (int i = 39; i <= 44; i++) begin
            checks++;
            if (r_set[8'(i)] !== (i == 39) || r_done[8'(i)] !== (i == 42) ||
                r_busy[8'(i)] !== (i < 42) || r_ld[8'(i)] !== 2'b00) begin
                errors++;
                $display("FAIL basic_ctrl T+%0d got set=%b done=%b busy=%b ld=%b expected %b %b %b 00", i,
                         r_set[8'(i)], r_done[8'(i)], r_busy[8'(i)], r_ld[8'(i)], i == 39, i == 42, i < 42);
            end
        end
    endtask

    task automatic test_addr_order();
        int nld;
        wr_entry(1'b0, 5'd12, 8'hEE);
        wr_entry(1'b1, 5'd25, 8'hDD);
        wr_entry(1'b0, 5'd31, 8'hCC);
        rd_lane = 2'd0; rd_addr = 5'd12;
        @(negedge clk_div);
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL hole_read got %h expected 00", rd_data); end
        rd_addr = 5'd6;
        @(negedge clk_div);
        checks++;
        if (rd_data !== exp_tbl[0][6]) begin
            errors++; $display("FAIL hole_alias_l0a6 got %h expected %h", rd_data, exp_tbl[0][6]);
        end
        rd_addr = 5'd0;
        @(negedge clk_div);
        checks++;
        if (rd_data !== exp_tbl[0][0]) begin
            errors++; $display("FAIL hole_alias_l0a0 got %h expected %h", rd_data, exp_tbl[0][0]);
        end
        rd_lane = 2'd1;
        @(negedge clk_div);
        checks++;
        if (rd_data !== exp_tbl[1][0]) begin
            errors++; $display("FAIL hole_alias_l1a0 got %h expected %h", rd_data, exp_tbl[1][0]);
        end
        kick();
        run_capture(44, 0, 0, 2'd0, 5'd0, 8'h00);
        nld = 0;
        for (int i = 1; i <= 44; i++) begin
            if (r_ld[8'(i)] != 2'b00) begin
                checks++;
                if (r_addr[8'(i)] !== 5'(seq_addr(nld)) || !addr_ok(r_addr[8'(i)])) begin
                    errors++;
                    $display("FAIL order_seq T+%0d got addr=%0d expected %0d", i, r_addr[8'(i)], seq_addr(nld));
                end
                nld++;
            end
        end
        checks++;
        if (nld != 38) begin errors++; $display("FAIL order_count got %0d expected 38", nld); end
    endtask

    task automatic test_apply_during_load();
        kick();
        run_capture(86, 10, 0, 2'd0, 5'd0, 8'h00);
        for (int i = 1; i <= 86; i++) begin
            checks++;
            if (r_done[8'(i)] !== (i == 42 || i == 84) || r_busy[8'(i)] !== !(i == 42 || i >= 84) ||
                r_set[8'(i)] !== (i == 39 || i == 81)) begin
                errors++;
                $display("FAIL pend_ctrl T+%0d got done=%b busy=%b set=%b", i, r_done[8'(i)], r_busy[8'(i)], r_set[8'(i)]);
            end
        end
        for (int j = 0; j < 38; j++) begin
            checks++;
            if (r_ld[8'(j + 43)] !== seq_ld(j) || r_addr[8'(j + 43)] !== 5'(seq_addr(j)) ||
                r_data[8'(j + 43)] !== exp_tbl[1'(j / 19)][5'(seq_addr(j))]) begin
                errors++;
                $display("FAIL pend_pass2 T+%0d got ld=%b addr=%0d data=%h expected ld=%b addr=%0d", j + 43,
                         r_ld[8'(j + 43)], r_addr[8'(j + 43)], r_data[8'(j + 43)], seq_ld(j), seq_addr(j));
            end
        end
        checks++;
        if (r_ld[42] !== 2'b00 || r_ld[81] !== 2'b00) begin
            errors++; $display("FAIL pend_gap got ld42=%b ld81=%b expected 00 00", r_ld[42], r_ld[81]);
        end
    endtask

    task automatic test_write_during_pass();
        kick();
        run_capture(86, 0, 5, 2'd1, 5'd5, 8'h33);
        checks++;
        if (r_ld[25] !== 2'b10 || r_addr[25] !== 5'd5 || r_data[25] !== 8'h33) begin
            errors++;
            $display("FAIL wrpass_p1 got ld=%b addr=%0d data=%h expected 10 5 33", r_ld[25], r_addr[25], r_data[25]);
        end
        checks++;
        if (r_ld[67] !== 2'b10 || r_addr[67] !== 5'd5 || r_data[67] !== 8'h33) begin
            errors++;
            $display("FAIL wrpass_p2 got ld=%b addr=%0d data=%h expected 10 5 33", r_ld[67], r_addr[67], r_data[67]);
        end
        checks++;
        if (r_done[42] !== 1'b1 || r_done[84] !== 1'b1 || r_busy[85] !== 1'b0 || r_ld[43] !== 2'b01) begin
            errors++;
            $display("FAIL wrpass_ctrl got done42=%b done84=%b busy85=%b ld43=%b expected 1 1 0 01",
                     r_done[42], r_done[84], r_busy[85], r_ld[43]);
        end
    endtask

    task automatic test_apply_with_write();
        apply = 1'b1; wr_en = 1'b1; wr_lane = 2'd0; wr_addr = 5'd0; wr_data = 8'h77;
        exp_tbl[0][0] = 8'h77;
        @(negedge clk_div);
        apply = 1'b0; wr_en = 1'b0;
        run_capture(86, 0, 0, 2'd0, 5'd0, 8'h00);
        checks++;
        if (r_ld[1] !== 2'b01 || r_addr[1] !== 5'd0 || r_data[1] !== 8'h77) begin
            errors++;
            $display("FAIL aw_first got ld=%b addr=%0d data=%h expected 01 0 77", r_ld[1], r_addr[1], r_data[1]);
        end
        checks++;
        if (r_done[42] !== 1'b1 || r_done[84] !== 1'b1 || r_data[43] !== 8'h77 || r_busy[86] !== 1'b0) begin
            errors++;
            $display("FAIL aw_extra got done42=%b done84=%b data43=%h busy86=%b expected 1 1 77 0",
                     r_done[42], r_done[84], r_data[43], r_busy[86]);
        end
    endtask

    task automatic test_rst_mid();
        bit seen;
        kick();
        repeat (19) @(negedge clk_div);
        @(posedge clk_div);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ld_delay, set, busy, done, dly_data, dly_addr, rd_data} !== '0) begin
            errors++;
            $display("FAIL rst_abort got ld=%b set=%b busy=%b done=%b data=%h addr=%0d rd=%h expected zeros",
                     ld_delay, set, busy, done, dly_data, dly_addr, rd_data);
        end
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk_div);
            if (set !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (45) begin
            @(negedge clk_div);
            if (set !== 1'b0 || busy !== 1'b0 || ld_delay !== 2'b00) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rst_quiet got activity after reset expected none"); end
        rd_lane = 2'd0; rd_addr = 5'd3;
        @(negedge clk_div);
        checks++;
        if (rd_data !== 8'h5A) begin errors++; $display("FAIL rst_retain got %h expected 5a", rd_data); end
    endtask

    task automatic test_readback();
        rd_lane = 2'd1; rd_addr = 5'd24;
        #1;
        checks++;
        if (rd_data !== 8'h5A) begin errors++; $display("FAIL rd_latency got %h expected 5a", rd_data); end
        @(negedge clk_div);
        checks++;
        if (rd_data !== 8'hC7) begin errors++; $display("FAIL rd_new_addr got %h expected c7", rd_data); end
        wr_en = 1'b1; wr_lane = 2'd1; wr_addr = 5'd24; wr_data = 8'h11;
        @(negedge clk_div);
        wr_en = 1'b0;
        checks++;
        if (rd_data !== 8'hC7) begin errors++; $display("FAIL rd_old_on_write got %h expected c7", rd_data); end
        @(negedge clk_div);
        checks++;
        if (rd_data !== 8'h11) begin errors++; $display("FAIL rd_after_write got %h expected 11", rd_data); end
    endtask

    initial begin
        test_reset();
        init_table();
        test_basic();
        test_addr_order();
        test_apply_during_load();
        test_write_during_pass();
        test_apply_with_write();
        test_rst_mid();
        test_readback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
